// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- sequencing FSM for the 2-way, 256-set D-cache tag/dirty/LRU RAM.
//
// Takes one CPU load/store at a time, compares both ways' tags, and on a
// hit finishes the access (stores also rewrite the tag entry to set dirty).
// On a miss it writes back a dirty victim to L2, refills from L2 and
// rewrites the victim's tag entry. Control only; line data moves elsewhere.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req, we, addr       CPU request (held until done), store flag, byte address
//   done, stall         completion pulse, pipeline stall (req & ~done)
//   hit_way             way holding the line, valid with done
//   index               tag RAM set address (read data valid one cycle later)
//   block0/1_rw         tag RAM per-way write strobes
//   dirty_wd, tag_wd    tag RAM write data
//   tag0/1_rd, dirty0/1 tag RAM read data
//   lru                 1: way0 most recently written (victim is way1)
//   complete            tag RAM write acknowledge
//   l2_rd_req/l2_wr_req L2 line refill / write-back requests
//   l2_addr, l2_ack     L2 line address {tag, index}, L2 handshake done

module dcache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    output logic                       done,
    output logic                       stall,
    output logic                       hit_way,
    output logic [INDEX_W-1:0]         index,
    output logic                       block0_rw,
    output logic                       block1_rw,
    output logic                       dirty_wd,
    output logic [TAG_W-1:0]           tag_wd,
    input  logic [TAG_W-1:0]           tag0_rd,
    input  logic [TAG_W-1:0]           tag1_rd,
    input  logic                       dirty0,
    input  logic                       dirty1,
    input  logic                       lru,
    input  logic                       complete,
    output logic                       l2_rd_req,
    output logic                       l2_wr_req,
    output logic [TAG_W-2+INDEX_W:0]   l2_addr,
    input  logic                       l2_ack
);
    localparam int LTAG_W = TAG_W - 1;          // address tag bits, without valid
    localparam int TAG_LO = ADDR_W - LTAG_W;    // lowest address bit of the tag
    localparam int IDX_LO = TAG_LO - INDEX_W;   // lowest address bit of the index
    localparam int LINE_W = ADDR_W - IDX_LO;    // {tag, index}

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_WRHIT, S_WB, S_RD, S_FILL, S_WAITC
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   addr_q, addr_d;      // latched {tag, index}
    logic                we_q, we_d;
    logic                way_q, way_d;        // hit way or victim way
    logic [LTAG_W-1:0]   tag_q, tag_d;        // stored tag of hit way / victim
    logic                done_q, done_d;
    logic                hit_way_q, hit_way_d;

    logic [LTAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0]  index_q;
    logic                hit0, hit1;
    logic [TAG_W-1:0]    victim_tag;
    logic                victim_dirty;
    logic                unused_addr_bits;

    // Byte offset within the line is irrelevant to the tag controller.
    assign unused_addr_bits = ^addr[IDX_LO-1:0];

    assign req_tag      = addr_q[LINE_W-1 -: LTAG_W];
    assign index_q      = addr_q[INDEX_W-1:0];
    assign hit0         = tag0_rd[TAG_W-1] & (tag0_rd[LTAG_W-1:0] == req_tag);
    assign hit1         = tag1_rd[TAG_W-1] & (tag1_rd[LTAG_W-1:0] == req_tag);
    // lru=1 means way0 was written last, so way1 is the victim.
    assign victim_tag   = lru ? tag1_rd : tag0_rd;
    assign victim_dirty = lru ? dirty1 : dirty0;

    assign done    = done_q;
    assign hit_way = hit_way_q;
    assign stall   = ~rst & req & ~done_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        way_d     = way_q;
        tag_d     = tag_q;
        done_d    = 1'b0;
        hit_way_d = 1'b0;
        index     = index_q;
        block0_rw = 1'b0;
        block1_rw = 1'b0;
        dirty_wd  = 1'b0;
        tag_wd    = '0;
        l2_rd_req = 1'b0;
        l2_wr_req = 1'b0;
        l2_addr   = '0;

        case (state_q)
            S_IDLE: begin
                index = addr[IDX_LO +: INDEX_W];
                // done_q guards against re-accepting the request that is
                // still held high during its own completion cycle.
                if (req && !done_q) begin
                    addr_d  = addr[ADDR_W-1:IDX_LO];
                    we_d    = we;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (hit0 || hit1) begin
                    way_d = ~hit0;                      // way0 wins a double hit
                    tag_d = hit0 ? tag0_rd[LTAG_W-1:0] : tag1_rd[LTAG_W-1:0];
                    if (we_q) begin
                        state_d = S_WRHIT;
                    end else begin
                        done_d    = 1'b1;
                        hit_way_d = ~hit0;
                        state_d   = S_IDLE;
                    end
                end else begin
                    way_d   = lru;
                    tag_d   = victim_tag[LTAG_W-1:0];
                    state_d = (victim_tag[TAG_W-1] && victim_dirty) ? S_WB : S_RD;
                end
            end
            S_WRHIT: begin
                block0_rw = ~way_q;
                block1_rw = way_q;
                tag_wd    = {1'b1, tag_q};
                dirty_wd  = 1'b1;
                state_d   = S_WAITC;
            end
            S_WB: begin
                l2_wr_req = 1'b1;
                l2_addr   = {tag_q, index_q};
                if (l2_ack) state_d = S_RD;
            end
            S_RD: begin
                l2_rd_req = 1'b1;
                l2_addr   = {req_tag, index_q};
                if (l2_ack) state_d = S_FILL;
            end
            S_FILL: begin
                block0_rw = ~way_q;
                block1_rw = way_q;
                tag_wd    = {1'b1, req_tag};
                dirty_wd  = we_q;
                state_d   = S_WAITC;
            end
            S_WAITC: begin
                if (complete) begin
                    done_d    = 1'b1;
                    hit_way_d = way_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs go quiet the moment reset asserts, not at the next edge.
        if (rst) begin
            index     = '0;
            block0_rw = 1'b0;
            block1_rw = 1'b0;
            dirty_wd  = 1'b0;
            tag_wd    = '0;
            l2_rd_req = 1'b0;
            l2_wr_req = 1'b0;
            l2_addr   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            way_q     <= 1'b0;
            tag_q     <= '0;
            done_q    <= 1'b0;
            hit_way_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            way_q     <= way_d;
            tag_q     <= tag_d;
            done_q    <= done_d;
            hit_way_q <= hit_way_d;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: behavioural tag RAM and L2 responders, directed
// scenarios, then random requests checked against a per-set cache model.
module tb_dcache_ctrl;
    logic        clk, rst, req, we;
    logic [31:0] addr;
    logic        done, stall, hit_way;
    logic [7:0]  index;
    logic        block0_rw, block1_rw, dirty_wd;
    logic [20:0] tag_wd, tag0_rd, tag1_rd;
    logic        dirty0, dirty1, lru, complete;
    logic        l2_rd_req, l2_wr_req, l2_ack;
    logic [27:0] l2_addr;

    int checks = 0;
    int errors = 0;

    dcache_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
        .done(done), .stall(stall), .hit_way(hit_way), .index(index),
        .block0_rw(block0_rw), .block1_rw(block1_rw), .dirty_wd(dirty_wd),
        .tag_wd(tag_wd), .tag0_rd(tag0_rd), .tag1_rd(tag1_rd),
        .dirty0(dirty0), .dirty1(dirty1), .lru(lru), .complete(complete),
        .l2_rd_req(l2_rd_req), .l2_wr_req(l2_wr_req), .l2_addr(l2_addr),
        .l2_ack(l2_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- tag RAM responder ----------------
    logic [20:0] m_tag0 [256];
    logic [20:0] m_tag1 [256];
    logic        m_d0 [256];
    logic        m_d1 [256];
    logic        m_lru [256];
    logic [7:0]  rd_idx;
    logic        ram_clr, pl_en, pl_way, pl_dirty, pl_lru;
    logic [7:0]  pl_idx;
    logic [20:0] pl_tag;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) begin
                m_tag0[i] <= '0; m_tag1[i] <= '0;
                m_d0[i] <= 1'b0; m_d1[i] <= 1'b0; m_lru[i] <= 1'b0;
            end
        end else if (pl_en) begin
            if (pl_way) begin m_tag1[pl_idx] <= pl_tag; m_d1[pl_idx] <= pl_dirty; end
            else        begin m_tag0[pl_idx] <= pl_tag; m_d0[pl_idx] <= pl_dirty; end
            m_lru[pl_idx] <= pl_lru;
        end else begin
            if (block0_rw) begin m_tag0[index] <= tag_wd; m_d0[index] <= dirty_wd; m_lru[index] <= 1'b1; end
            if (block1_rw) begin m_tag1[index] <= tag_wd; m_d1[index] <= dirty_wd; m_lru[index] <= 1'b0; end
        end
        rd_idx   <= index;
        complete <= rst ? 1'b0 : (block0_rw | block1_rw);
    end
    assign tag0_rd = m_tag0[rd_idx];
    assign tag1_rd = m_tag1[rd_idx];
    assign dirty0  = m_d0[rd_idx];
    assign dirty1  = m_d1[rd_idx];
    assign lru     = m_lru[rd_idx];

    // ---------------- L2 responder: ack arrives in request cycle l2_lat ----------------
    int l2_lat;
    int l2_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            l2_ack <= 1'b0; l2_cnt <= 0;
        end else if (l2_ack) begin
            l2_ack <= 1'b0; l2_cnt <= 0;
        end else if (l2_rd_req || l2_wr_req) begin
            if (l2_cnt >= l2_lat - 2) begin l2_ack <= 1'b1; l2_cnt <= 0; end
            else l2_cnt <= l2_cnt + 1;
        end
    end

    // ---------------- reference cache state ----------------
    logic [20:0] r_tag [2][256];
    logic        r_d [2][256];
    logic        r_lru [256];   // 1: way0 written last

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic preload(input logic way, input logic [7:0] idx, input logic [20:0] t,
                           input logic d, input logic l);
        r_tag[way][idx] = t; r_d[way][idx] = d; r_lru[idx] = l;
        @(posedge clk); #1;
        pl_en = 1'b1; pl_way = way; pl_idx = idx; pl_tag = t; pl_dirty = d; pl_lru = l;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic run_req(input logic [31:0] a, input logic w, input int lat);
        logic [7:0]  idx;
        logic [19:0] t;
        logic        h0, h1, hit, way, ewb, erd, ewr;
        logic [27:0] ewb_addr, erd_addr;
        logic [20:0] etag;
        logic        edw;
        int cyc, nwb, nrd, nwr, cmp_cyc, done_cyc;
        logic got, ohw, wway, wdw;
        logic [27:0] wb_addr, rd_addr;
        logic [20:0] wtag;

        // expectation from the reference state
        idx = a[11:4]; t = a[31:12];
        h0 = r_tag[0][idx][20] && (r_tag[0][idx][19:0] == t);
        h1 = r_tag[1][idx][20] && (r_tag[1][idx][19:0] == t);
        hit = h0 | h1;
        ewb = 1'b0; erd = 1'b0; ewr = 1'b0; ewb_addr = '0; erd_addr = '0; etag = '0; edw = 1'b0;
        if (hit) begin
            way = h0 ? 1'b0 : 1'b1;
            if (w) begin
                ewr = 1'b1; etag = r_tag[way][idx]; edw = 1'b1;
                r_d[way][idx] = 1'b1; r_lru[idx] = (way == 1'b0);
            end
        end else begin
            way = r_lru[idx];            // least recently written way
            if (r_tag[way][idx][20] && r_d[way][idx]) begin
                ewb = 1'b1; ewb_addr = {r_tag[way][idx][19:0], idx};
            end
            erd = 1'b1; erd_addr = {t, idx};
            ewr = 1'b1; etag = {1'b1, t}; edw = w;
            r_tag[way][idx] = {1'b1, t}; r_d[way][idx] = w; r_lru[idx] = (way == 1'b0);
        end

        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; l2_lat = lat;
        cyc = 0; nwb = 0; nrd = 0; nwr = 0; cmp_cyc = -10; done_cyc = -1; got = 1'b0;
        ohw = 1'b0; wway = 1'b0; wdw = 1'b0; wtag = '0; wb_addr = '0; rd_addr = '0;
        while (!got && cyc < 300) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            check("stall", {31'd0, stall}, {31'd0, req & ~done});
            check("l2_excl", {31'd0, l2_rd_req & l2_wr_req}, 32'd0);
            check("rw_excl", {31'd0, block0_rw & block1_rw}, 32'd0);
            check("index", {24'd0, index}, {24'd0, a[11:4]});
            if (l2_wr_req && l2_ack) begin nwb++; wb_addr = l2_addr; end
            if (l2_rd_req && l2_ack) begin nrd++; rd_addr = l2_addr; end
            if (block0_rw || block1_rw) begin
                nwr++; wway = block1_rw; wdw = dirty_wd; wtag = tag_wd;
            end
            if (complete) cmp_cyc = cyc;
            if (done) begin got = 1'b1; done_cyc = cyc; ohw = hit_way; end
        end
        @(posedge clk); #1;
        req = 1'b0;

        check("done_seen", {31'd0, got}, 32'd1);
        check("hit_way", {31'd0, ohw}, {31'd0, way});
        check("n_wb", nwb, {31'd0, ewb});
        if (ewb) check("wb_addr", {4'd0, wb_addr}, {4'd0, ewb_addr});
        check("n_rd", nrd, {31'd0, erd});
        if (erd) check("rd_addr", {4'd0, rd_addr}, {4'd0, erd_addr});
        check("n_tag_wr", nwr, {31'd0, ewr});
        if (ewr) begin
            check("wr_way", {31'd0, wway}, {31'd0, way});
            check("wr_dirty", {31'd0, wdw}, {31'd0, edw});
            check("wr_tag", {11'd0, wtag}, {11'd0, etag});
            check("done_after_complete", done_cyc, cmp_cyc + 1);
        end else begin
            check("rdhit_latency", done_cyc, 2);
        end
        $display("txn addr=%h we=%0b %s way=%0d wb=%0d rd=%0d tagwr=%0d done_cyc=%0d",
                 a, w, hit ? "hit " : "miss", way, nwb, nrd, nwr, done_cyc);
    endtask

    initial begin
        logic seen;
        logic [7:0]  ridx;
        logic [19:0] rtag;
        logic [31:0] ra;

        rst = 1'b1; ram_clr = 1'b1; pl_en = 1'b0; pl_way = 1'b0; pl_idx = '0;
        pl_tag = '0; pl_dirty = 1'b0; pl_lru = 1'b0; l2_lat = 3;
        req = 1'b1; we = 1'b0; addr = 32'hFFFF_FFF0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++) begin r_tag[w][i] = '0; r_d[w][i] = 1'b0; end
        for (int i = 0; i < 256; i++) r_lru[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ram_clr = 1'b0;
        // reset state, with a request and a nonzero address applied
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_index", {24'd0, index}, 32'd0);
        check("rst_l2_rd", {31'd0, l2_rd_req}, 32'd0);
        check("rst_l2_addr", {4'd0, l2_addr}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // read miss into an empty set, L2 ack on third RD cycle
        run_req(32'h0000_1230, 1'b0, 3);
        // read hit in way1
        preload(1'b1, 8'h45, 21'h1ABCDE, 1'b0, 1'b0);
        run_req(32'hABCD_E450, 1'b0, 3);
        // write hit in way0
        preload(1'b0, 8'h00, 21'h100001, 1'b0, 1'b0);
        run_req(32'h0000_1004, 1'b1, 3);
        // dirty victim in way1 written back before refill
        preload(1'b1, 8'h67, 21'h1FFFFF, 1'b1, 1'b1);
        run_req(32'h1234_5670, 1'b0, 2);
        // both ways hold the same tag: way0 wins
        preload(1'b1, 8'h00, 21'h100001, 1'b0, 1'b0);
        run_req(32'h0000_1000, 1'b0, 3);

        // reset in the middle of an L2 refill
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h0000_5300; l2_lat = 20;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = l2_rd_req;
        end
        check("rd_before_reset", {31'd0, seen}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_l2_rd", {31'd0, l2_rd_req}, 32'd0);
        check("midrst_l2_wr", {31'd0, l2_wr_req}, 32'd0);
        check("midrst_l2_addr", {4'd0, l2_addr}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_rw", {30'd0, block1_rw, block0_rw}, 32'd0);
        check("midrst_tag_wd", {11'd0, tag_wd}, 32'd0);
        check("midrst_dirty_wd", {31'd0, dirty_wd}, 32'd0);
        check("midrst_index", {24'd0, index}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        // back in IDLE: no L2 request, index follows the live address
        check("postrst_l2_rd", {31'd0, l2_rd_req}, 32'd0);
        check("postrst_index", {24'd0, index}, 32'h30);
        run_req(32'h0000_5300, 1'b1, 2);

        // random requests over a few sets and tags to mix hits, misses, evictions
        for (int n = 0; n < 60; n++) begin
            ridx = 8'h10 + 8'($urandom_range(0, 3));
            rtag = 20'h00100 + 20'($urandom_range(0, 3));
            ra = {rtag, ridx, 4'($urandom)};
            run_req(ra, 1'($urandom), int'($urandom_range(2, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
